// File: rtl/stack_pointer_unit_if.sv
// Stack pointer bus bundle: decoder strobes in, stack bus / address bus drivers out.
// Carries low_mark only when SP_WATERMARK_EN is defined.
interface stack_pointer_unit_if #(
  parameter int unsigned WIDTH = 8
);
  logic             load_en;
  logic [WIDTH-1:0] bus_in;
  logic             push;
  logic             pull;
  logic             clr_flags;
  logic             bus_out_en;
  logic [WIDTH-1:0] bus_out;
  logic             abl_out_en;
  logic [WIDTH-1:0] abl_out;
  logic [7:0]       abh_out;
  logic             busy;
  logic             pull_ready;
  logic             overflow;
  logic             underflow;
  logic             conflict;
`ifdef SP_WATERMARK_EN
  logic [WIDTH-1:0] low_mark;
`endif

  modport master (
    output load_en, bus_in, push, pull, clr_flags, bus_out_en, abl_out_en,
    input  bus_out, abl_out, abh_out, busy, pull_ready, overflow, underflow, conflict
`ifdef SP_WATERMARK_EN
    , input low_mark
`endif
  );

  modport slave (
    input  load_en, bus_in, push, pull, clr_flags, bus_out_en, abl_out_en,
    output bus_out, abl_out, abh_out, busy, pull_ready, overflow, underflow, conflict
`ifdef SP_WATERMARK_EN
    , output low_mark
`endif
  );
endinterface

// File: rtl/stack_pointer_unit.sv
// 8227 stack pointer: post-decrement push, pre-increment pull with a one-cycle PULL_RD
// state, sticky wrap/conflict flags. Optional minimum-SP tracking under SP_WATERMARK_EN.
module stack_pointer_unit #(
  parameter int unsigned      WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'('hFF),
  parameter logic [7:0]       PAGE_HIGH   = 8'h01
) (
  input  logic                 clk,
  input  logic                 rst,
  stack_pointer_unit_if.slave  sp_bus
);

  typedef enum logic {IDLE, PULL_RD} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sp_q, sp_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             conf_q, conf_d;
  logic             ovf_set, unf_set, conf_set, dec;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sp_q    <= RESET_VALUE;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      conf_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sp_q    <= sp_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      conf_q  <= conf_d;
    end
  end

  always_comb begin
    state_d  = IDLE;
    sp_d     = sp_q;
    ovf_set  = 1'b0;
    unf_set  = 1'b0;
    conf_set = 1'b0;
    dec      = 1'b0;
    if (sp_bus.load_en) begin
      sp_d = sp_bus.bus_in;
    end else if (state_q == IDLE) begin
      if (sp_bus.push && sp_bus.pull) begin
        conf_set = 1'b1;
      end else if (sp_bus.push) begin
        sp_d    = sp_q - WIDTH'(1);
        ovf_set = (sp_q == '0);
        dec     = 1'b1;
      end else if (sp_bus.pull) begin
        sp_d    = sp_q + WIDTH'(1);
        unf_set = (sp_q == '1);
        state_d = PULL_RD;
      end
    end
    // A flag being set in the same cycle wins over clr_flags; load clears unconditionally.
    if (sp_bus.load_en) begin
      ovf_d  = 1'b0;
      unf_d  = 1'b0;
      conf_d = 1'b0;
    end else begin
      ovf_d  = ovf_set  | (ovf_q  & ~sp_bus.clr_flags);
      unf_d  = unf_set  | (unf_q  & ~sp_bus.clr_flags);
      conf_d = conf_set | (conf_q & ~sp_bus.clr_flags);
    end
  end

`ifdef SP_WATERMARK_EN
  logic [WIDTH-1:0] lm_q, lm_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lm_q <= RESET_VALUE;
    else     lm_q <= lm_d;
  end

  always_comb begin
    lm_d = lm_q;
    if (ovf_set)                                lm_d = '0;
    else if (sp_bus.load_en || sp_bus.clr_flags) lm_d = sp_d;
    else if (dec && (sp_d < lm_q))              lm_d = sp_d;
  end

  assign sp_bus.low_mark = lm_q;
`endif

  assign sp_bus.bus_out    = sp_bus.bus_out_en ? sp_q : 'z;
  assign sp_bus.abl_out    = sp_bus.abl_out_en ? sp_q : 'z;
  assign sp_bus.abh_out    = sp_bus.abl_out_en ? PAGE_HIGH : 'z;
  assign sp_bus.busy       = (state_q == PULL_RD);
  assign sp_bus.pull_ready = (state_q == PULL_RD);
  assign sp_bus.overflow   = ovf_q;
  assign sp_bus.underflow  = unf_q;
  assign sp_bus.conflict   = conf_q;

endmodule

// File: tb/tb_stack_pointer_unit.sv
// Scoreboard bench for stack_pointer_unit: expectations queued at stimulus, popped at sample.
module tb_stack_pointer_unit;

  typedef struct {
    string      nm;
    logic [7:0] v;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   passes;
  exp_t sb[$];
  exp_t e;

  stack_pointer_unit_if #(.WIDTH(8)) spif ();

  stack_pointer_unit #(
    .WIDTH(8),
    .RESET_VALUE(8'hFF),
    .PAGE_HIGH(8'h01)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sp_bus(spif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    spif.load_en    = 1'b0;
    spif.bus_in     = 8'h00;
    spif.push       = 1'b0;
    spif.pull       = 1'b0;
    spif.clr_flags  = 1'b0;
  endtask

  task automatic chk(input string nm, input logic [7:0] obs);
    e = sb.pop_front();
    checks++;
    if (e.nm != nm) $display("FAIL %s: scoreboard order got %s", nm, e.nm);
    else if (obs !== e.v) $display("FAIL %s: got %h want %h", nm, obs, e.v);
    else passes++;
  endtask

  task automatic test_reset();
    idle_inputs();
    spif.bus_out_en = 1'b0;
    spif.abl_out_en = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    sb.push_back('{"rst_bus_z", 8'hzz});
    sb.push_back('{"rst_abl_z", 8'hzz});
    sb.push_back('{"rst_abh_z", 8'hzz});
    sb.push_back('{"rst_flags", 8'h00});
    sb.push_back('{"rst_busy", 8'h00});
    chk("rst_bus_z", spif.bus_out);
    chk("rst_abl_z", spif.abl_out);
    chk("rst_abh_z", spif.abh_out);
    chk("rst_flags", {5'b0, spif.overflow, spif.underflow, spif.conflict});
    chk("rst_busy", {6'b0, spif.busy, spif.pull_ready});
    spif.bus_out_en = 1'b1;
    #1;
    sb.push_back('{"rst_sp", 8'hFF});
    chk("rst_sp", spif.bus_out);
  endtask

  task automatic test_push();
    @(negedge clk);
    spif.push = 1'b1;
    spif.abl_out_en = 1'b1;
    #1;
    sb.push_back('{"push_abl", 8'hFF});
    sb.push_back('{"push_abh", 8'h01});
    chk("push_abl", spif.abl_out);
    chk("push_abh", spif.abh_out);
    @(negedge clk);
    spif.push = 1'b0;
    #1;
    sb.push_back('{"push_sp", 8'hFE});
    sb.push_back('{"push_busy", 8'h00});
    chk("push_sp", spif.bus_out);
    chk("push_busy", {7'b0, spif.busy});
  endtask

  task automatic test_pull();
    @(negedge clk);
    spif.push = 1'b1;               // FE -> FD
    @(negedge clk);
    spif.push = 1'b0;
    #1;
    sb.push_back('{"pull_pre_sp", 8'hFD});
    chk("pull_pre_sp", spif.bus_out);
    spif.pull = 1'b1;
    @(negedge clk);                 // now in PULL_RD; pull held high must be ignored
    #1;
    sb.push_back('{"pull_rd_busy", 8'h03});
    sb.push_back('{"pull_rd_abl", 8'hFE});
    chk("pull_rd_busy", {6'b0, spif.busy, spif.pull_ready});
    chk("pull_rd_abl", spif.abl_out);
    @(negedge clk);
    spif.pull = 1'b0;
    #1;
    sb.push_back('{"pull_idle_busy", 8'h00});
    sb.push_back('{"pull_repeat_sp", 8'hFE});
    chk("pull_idle_busy", {6'b0, spif.busy, spif.pull_ready});
    chk("pull_repeat_sp", spif.bus_out);
  endtask

  task automatic test_wrap();
    @(negedge clk);
    spif.load_en = 1'b1; spif.bus_in = 8'h00;
    @(negedge clk);
    spif.load_en = 1'b0; spif.push = 1'b1;
    @(negedge clk);
    spif.push = 1'b0;
    #1;
    sb.push_back('{"ovf_sp", 8'hFF});
    sb.push_back('{"ovf_flag", 8'h01});
    chk("ovf_sp", spif.bus_out);
    chk("ovf_flag", {7'b0, spif.overflow});
    spif.load_en = 1'b1; spif.bus_in = 8'hFF;
    @(negedge clk);
    spif.load_en = 1'b0;
    #1;
    sb.push_back('{"load_clr_ovf", 8'h00});
    chk("load_clr_ovf", {7'b0, spif.overflow});
    spif.pull = 1'b1;
    @(negedge clk);
    spif.pull = 1'b0;
    #1;
    sb.push_back('{"unf_sp", 8'h00});
    sb.push_back('{"unf_flag", 8'h01});
    chk("unf_sp", spif.bus_out);
    chk("unf_flag", {7'b0, spif.underflow});
    @(negedge clk);
    spif.load_en = 1'b1; spif.bus_in = 8'h10;
    @(negedge clk);
    spif.load_en = 1'b0;
    #1;
    sb.push_back('{"load_clr_unf", 8'h00});
    sb.push_back('{"load_sp", 8'h10});
    chk("load_clr_unf", {7'b0, spif.underflow});
    chk("load_sp", spif.bus_out);
  endtask

  task automatic test_conflict();
    @(negedge clk);
    spif.load_en = 1'b1; spif.bus_in = 8'h80;
    @(negedge clk);
    spif.load_en = 1'b0; spif.push = 1'b1; spif.pull = 1'b1;
    @(negedge clk);
    spif.push = 1'b0; spif.pull = 1'b0;
    #1;
    sb.push_back('{"conf_sp", 8'h80});
    sb.push_back('{"conf_flag", 8'h01});
    sb.push_back('{"conf_busy", 8'h00});
    chk("conf_sp", spif.bus_out);
    chk("conf_flag", {7'b0, spif.conflict});
    chk("conf_busy", {7'b0, spif.busy});
    spif.clr_flags = 1'b1;
    @(negedge clk);
    spif.clr_flags = 1'b0;
    #1;
    sb.push_back('{"clr_conf", 8'h00});
    chk("clr_conf", {7'b0, spif.conflict});
    // wrap in the same cycle as clr_flags: set must win
    spif.load_en = 1'b1; spif.bus_in = 8'h00;
    @(negedge clk);
    spif.load_en = 1'b0; spif.push = 1'b1; spif.clr_flags = 1'b1;
    @(negedge clk);
    spif.push = 1'b0; spif.clr_flags = 1'b0;
    #1;
    sb.push_back('{"set_beats_clr", 8'h01});
    chk("set_beats_clr", {7'b0, spif.overflow});
  endtask

  task automatic test_reset_mid_pull();
    @(negedge clk);
    spif.load_en = 1'b1; spif.bus_in = 8'h40;
    @(negedge clk);
    spif.load_en = 1'b0; spif.pull = 1'b1;
    @(negedge clk);
    spif.pull = 1'b0;
    #1;
    sb.push_back('{"mid_busy", 8'h01});
    chk("mid_busy", {7'b0, spif.busy});
    rst = 1'b1;
    #1;
    sb.push_back('{"mid_rst_busy", 8'h00});
    sb.push_back('{"mid_rst_sp", 8'hFF});
    sb.push_back('{"mid_rst_ovf", 8'h00});
    chk("mid_rst_busy", {6'b0, spif.busy, spif.pull_ready});
    chk("mid_rst_sp", spif.bus_out);
    chk("mid_rst_ovf", {7'b0, spif.overflow});
    @(negedge clk);
    rst = 1'b0;
  endtask

`ifdef SP_WATERMARK_EN
  task automatic test_watermark();
    #1;
    sb.push_back('{"lm_reset", 8'hFF});
    chk("lm_reset", spif.low_mark);
    for (int unsigned i = 0; i < 3; i++) begin
      @(negedge clk);
      spif.push = 1'b1;
    end
    @(negedge clk);
    spif.push = 1'b0;
    spif.pull = 1'b1;
    #1;
    sb.push_back('{"lm_3push", 8'hFC});
    chk("lm_3push", spif.low_mark);
    @(negedge clk);
    spif.pull = 1'b0;
    @(negedge clk);
    #1;
    sb.push_back('{"lm_after_pull", 8'hFC});
    sb.push_back('{"lm_sp", 8'hFD});
    chk("lm_after_pull", spif.low_mark);
    chk("lm_sp", spif.bus_out);
  endtask
`endif

  initial begin
    checks = 0;
    passes = 0;
    test_reset();
    test_push();
    test_pull();
    test_wrap();
    test_conflict();
    test_reset_mid_pull();
`ifdef SP_WATERMARK_EN
    test_watermark();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
